hawk_att_lkup_resp: RTL and testbench

Responder side of the hawk ATT lookup handshake. It accepts a lookup request (host page address) from `hawk_ctrl_unit`, fetches the 8-byte ATT entry from DRAM over a simple read port, and decodes status and physical page address. It returns the translation packet (`ppa`, `sts`, `allow_access`) to the control unit. It sits inside the page read manager, between the control unit and the AXI read master.

---
 rtl/hawk_att_lkup_resp.sv | 217 +++++++++++++++++++++
 tb/tb_hawk_att_lkup_resp.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_att_lkup_resp.sv
// hawk ATT lookup responder: fetches an 8-byte ATT entry over the read port and returns the decoded translation.
// Optional one-entry translation cache, enabled by defining HAWK_ATT_LKUP_CACHE_EN.
module hawk_att_lkup_resp #(
    parameter int unsigned       ADDR_W      = 40,
    parameter logic [ADDR_W-1:0] ATT_BASE    = '0,
    parameter int unsigned       TIMEOUT_CYC = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               init_att_done,
    input  logic               att_inval,
    input  logic               lkup_valid,
    input  logic [ADDR_W-13:0] lkup_hppa,
    output logic               lkup_ready,
    output logic [ADDR_W-13:0] trnsl_ppa,
    output logic [1:0]         trnsl_sts,
    output logic               trnsl_allow,
    output logic               trnsl_done,
    output logic               trnsl_err,
    output logic               mem_rd_req,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic               mem_rd_gnt,
    input  logic               mem_rd_rvalid,
    input  logic [63:0]        mem_rd_rdata,
    input  logic               mem_rd_err
);

    localparam int unsigned      PPN_W    = ADDR_W - 12;
    localparam int unsigned      CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef struct packed {
        logic [PPN_W-1:0] ppa;
        logic [1:0]       sts;
    } trnsl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PPN_W-1:0]  hppa_q, hppa_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PPN_W-1:0]  ppa_q, ppa_d;
    logic [1:0]        sts_q, sts_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic              allow_q, allow_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              resp_en;
    logic              resp_err;
    trnsl_t            resp;
    trnsl_t            mem_entry;
    logic              cache_hit;
    trnsl_t            cache_entry;

    assign mem_entry = {mem_rd_rdata[ADDR_W-1:12], mem_rd_rdata[1:0]};

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d  = state_q;
        hppa_d   = hppa_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ppa_d    = ppa_q;
        sts_d    = sts_q;
        ready_d  = 1'b0;
        req_d    = 1'b0;
        allow_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        resp_en  = 1'b0;
        resp_err = 1'b0;
        resp     = mem_entry;

        case (state_q)
            IDLE: begin
                if (lkup_valid && ready_q) begin
                    hppa_d = lkup_hppa;
                    addr_d = ATT_BASE + ADDR_W'({lkup_hppa, 3'b000});
                    if (cache_hit) begin
                        state_d = RESP;
                        resp_en = 1'b1;
                        resp    = cache_entry;
                    end else begin
                        state_d = ISSUE;
                        req_d   = 1'b1;
                    end
                end else begin
                    ready_d = init_att_done;
                end
            end
            ISSUE: begin
                if (mem_rd_gnt && mem_rd_rvalid) begin
                    state_d  = RESP;
                    resp_en  = 1'b1;
                    resp_err = mem_rd_err;
                end else if (mem_rd_gnt) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    req_d = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rd_rvalid) begin
                    state_d  = RESP;
                    resp_en  = 1'b1;
                    resp_err = mem_rd_err;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = RESP;
                    resp_en  = 1'b1;
                    resp_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = init_att_done;
            end
            default: state_d = IDLE;
        endcase

        // Response pulses are loaded on entry to RESP; errors force a null translation.
        if (resp_en) begin
            done_d = 1'b1;
            err_d  = resp_err;
            if (resp_err) begin
                ppa_d = '0;
                sts_d = 2'b00;
            end else begin
                ppa_d   = resp.ppa;
                sts_d   = resp.sts;
                allow_d = resp.sts[0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hppa_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            ppa_q   <= '0;
            sts_q   <= 2'b00;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            allow_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hppa_q  <= hppa_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ppa_q   <= ppa_d;
            sts_q   <= sts_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            allow_q <= allow_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef HAWK_ATT_LKUP_CACHE_EN
    logic             c_valid_q;
    logic [PPN_W-1:0] c_hppa_q;
    trnsl_t           c_entry_q;

    // A lookup arriving with an invalidate must not hit on stale data.
    assign cache_hit   = c_valid_q && (c_hppa_q == lkup_hppa) && !att_inval;
    assign cache_entry = c_entry_q;

    // Invalidate takes priority over a fill in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_valid_q <= 1'b0;
            c_hppa_q  <= '0;
            c_entry_q <= '0;
        end else if (att_inval) begin
            c_valid_q <= 1'b0;
        end else if (resp_en && !resp_err) begin
            c_valid_q <= 1'b1;
            c_hppa_q  <= hppa_d;
            c_entry_q <= resp;
        end
    end

    logic unused_rdata;
    assign unused_rdata = ^{mem_rd_rdata[63:ADDR_W], mem_rd_rdata[11:2]};
`else
    assign cache_hit   = 1'b0;
    assign cache_entry = '0;

    logic unused_rdata;
    assign unused_rdata = ^{mem_rd_rdata[63:ADDR_W], mem_rd_rdata[11:2], att_inval};
`endif

    assign lkup_ready  = ready_q;
    assign mem_rd_req  = req_q;
    assign mem_rd_addr = addr_q;
    assign trnsl_ppa   = ppa_q;
    assign trnsl_sts   = sts_q;
    assign trnsl_allow = allow_q;
    assign trnsl_done  = done_q;
    assign trnsl_err   = err_q;

endmodule

// File: tb/tb_hawk_att_lkup_resp.sv
// Directed self-checking bench for hawk_att_lkup_resp (ATT_BASE = 'h1000, TIMEOUT_CYC = 8).
module tb_hawk_att_lkup_resp;

    localparam int unsigned ADDR_W = 40;
    localparam int unsigned PPN_W  = ADDR_W - 12;

    logic              clk_i;
    logic              rst_ni;
    logic              init_att_done;
    logic              att_inval;
    logic              lkup_valid;
    logic [PPN_W-1:0]  lkup_hppa;
    logic              lkup_ready;
    logic [PPN_W-1:0]  trnsl_ppa;
    logic [1:0]        trnsl_sts;
    logic              trnsl_allow;
    logic              trnsl_done;
    logic              trnsl_err;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_gnt;
    logic              mem_rd_rvalid;
    logic [63:0]       mem_rd_rdata;
    logic              mem_rd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_cnt  = 0;
    int done_cnt = 0;

    hawk_att_lkup_resp #(
        .ADDR_W     (ADDR_W),
        .ATT_BASE   (40'h1000),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .init_att_done(init_att_done),
        .att_inval    (att_inval),
        .lkup_valid   (lkup_valid),
        .lkup_hppa    (lkup_hppa),
        .lkup_ready   (lkup_ready),
        .trnsl_ppa    (trnsl_ppa),
        .trnsl_sts    (trnsl_sts),
        .trnsl_allow  (trnsl_allow),
        .trnsl_done   (trnsl_done),
        .trnsl_err    (trnsl_err),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_gnt   (mem_rd_gnt),
        .mem_rd_rvalid(mem_rd_rvalid),
        .mem_rd_rdata (mem_rd_rdata),
        .mem_rd_err   (mem_rd_err)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rst_ni && mem_rd_req && mem_rd_gnt) gnt_cnt++;
        if (trnsl_done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] ent(input logic [PPN_W-1:0] ppa, input logic [1:0] sts);
        return {24'h0, ppa, 10'h0, sts};
    endfunction

    // Presents a lookup for one cycle; returns at mid-cycle right after the sampling edge.
    task automatic issue_lookup(input logic [PPN_W-1:0] h, input logic inval);
        lkup_valid = 1'b1;
        lkup_hppa  = h;
        att_inval  = inval;
        @(negedge clk_i);
        lkup_valid = 1'b0;
        att_inval  = 1'b0;
    endtask

    // Called mid-ISSUE; returns mid-cycle of the expected RESP.
    task automatic mem_respond(input int gnt_wait, input int data_wait,
                               input logic [63:0] data, input logic err);
        repeat (gnt_wait) @(negedge clk_i);
        mem_rd_gnt = 1'b1;
        if (data_wait == 0) begin
            mem_rd_rvalid = 1'b1;
            mem_rd_rdata  = data;
            mem_rd_err    = err;
        end
        @(negedge clk_i);
        mem_rd_gnt = 1'b0;
        if (data_wait != 0) begin
            repeat (data_wait - 1) @(negedge clk_i);
            mem_rd_rvalid = 1'b1;
            mem_rd_rdata  = data;
            mem_rd_err    = err;
            @(negedge clk_i);
        end
        mem_rd_rvalid = 1'b0;
        mem_rd_err    = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; init_att_done = 1'b0; att_inval = 1'b0; lkup_valid = 1'b0;
        lkup_hppa = '0; mem_rd_gnt = 1'b0; mem_rd_rvalid = 1'b0; mem_rd_rdata = '0; mem_rd_err = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({lkup_ready, mem_rd_req, trnsl_allow, trnsl_done, trnsl_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {lkup_ready, mem_rd_req, trnsl_allow, trnsl_done, trnsl_err});
        end
        n_checks++;
        if ({mem_rd_addr, trnsl_ppa, trnsl_sts} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h ppa %h sts %b expected all zero", mem_rd_addr, trnsl_ppa, trnsl_sts);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        issue_lookup(28'h5, 1'b0);
        n_checks++;
        if (lkup_ready !== 1'b0 || mem_rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL init_gate: ready %b req %b expected 0 0", lkup_ready, mem_rd_req);
        end
        @(negedge clk_i);
        n_checks++;
        if (mem_rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL init_gate_req: got %b expected 0", mem_rd_req);
        end
        init_att_done = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (lkup_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_ready: got %b expected 1", lkup_ready);
        end
    endtask

    task automatic test_uncompressed;
        issue_lookup(28'h5, 1'b0);
        n_checks++;
        if (mem_rd_req !== 1'b1 || lkup_ready !== 1'b0 || mem_rd_addr !== 40'h1028) begin
            n_fail++;
            $display("FAIL unc_issue: req %b ready %b addr %h expected 1 0 1028", mem_rd_req, lkup_ready, mem_rd_addr);
        end
        mem_respond(0, 1, ent(28'hABCDE, 2'b01), 1'b0);
        n_checks++;
        if ({trnsl_done, trnsl_allow, trnsl_err} !== 3'b110 || trnsl_ppa !== 28'hABCDE || trnsl_sts !== 2'b01) begin
            n_fail++;
            $display("FAIL unc_resp: done/allow/err %b ppa %h sts %b expected 110 abcde 01",
                     {trnsl_done, trnsl_allow, trnsl_err}, trnsl_ppa, trnsl_sts);
        end
        @(negedge clk_i);
        n_checks++;
        if (trnsl_done !== 1'b0 || trnsl_allow !== 1'b0 || lkup_ready !== 1'b1 || trnsl_ppa !== 28'hABCDE) begin
            n_fail++;
            $display("FAIL unc_after: done %b allow %b ready %b ppa %h expected 0 0 1 abcde",
                     trnsl_done, trnsl_allow, lkup_ready, trnsl_ppa);
        end
    endtask

    task automatic test_compressed_unalloc;
        logic [1:0] sts_v [2];
        sts_v[0] = 2'b10;
        sts_v[1] = 2'b00;
        for (int i = 0; i < 2; i++) begin
            issue_lookup(28'h20 + 28'(i), 1'b0);
            @(negedge clk_i);
            n_checks++;
            if (mem_rd_req !== 1'b1 || mem_rd_addr !== 40'h1000 + 40'((28'h20 + 28'(i)) * 8)) begin
                n_fail++;
                $display("FAIL req_hold_%0d: req %b addr %h", i, mem_rd_req, mem_rd_addr);
            end
            mem_respond(0, 2, ent(28'h111 + 28'(i), sts_v[i]), 1'b0);
            n_checks++;
            if ({trnsl_done, trnsl_allow, trnsl_err} !== 3'b100 || trnsl_sts !== sts_v[i]) begin
                n_fail++;
                $display("FAIL noallow_%0d: done/allow/err %b sts %b expected 100 %b",
                         i, {trnsl_done, trnsl_allow, trnsl_err}, trnsl_sts, sts_v[i]);
            end
            @(negedge clk_i);
            n_checks++;
            if (lkup_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_%0d: got %b expected 1", i, lkup_ready);
            end
        end
    endtask

    task automatic test_rd_error;
        issue_lookup(28'h30, 1'b0);
        mem_respond(0, 1, ent(28'hFFFFF, 2'b01), 1'b1);
        n_checks++;
        if ({trnsl_done, trnsl_allow, trnsl_err} !== 3'b101 || trnsl_sts !== 2'b00 || trnsl_ppa !== '0) begin
            n_fail++;
            $display("FAIL rd_err: done/allow/err %b sts %b ppa %h expected 101 00 0",
                     {trnsl_done, trnsl_allow, trnsl_err}, trnsl_sts, trnsl_ppa);
        end
        @(negedge clk_i);
    endtask

    task automatic test_gnt_data_same_cycle;
        issue_lookup(28'h40, 1'b0);
        mem_respond(0, 0, ent(28'h5A5A, 2'b11), 1'b0);
        n_checks++;
        if ({trnsl_done, trnsl_allow, trnsl_err} !== 3'b110 || trnsl_ppa !== 28'h5A5A || trnsl_sts !== 2'b11) begin
            n_fail++;
            $display("FAIL same_cycle: done/allow/err %b ppa %h sts %b expected 110 5a5a 11",
                     {trnsl_done, trnsl_allow, trnsl_err}, trnsl_ppa, trnsl_sts);
        end
        @(negedge clk_i);
    endtask

    task automatic test_timeout;
        int d0;
        issue_lookup(28'h41, 1'b0);
        mem_rd_gnt = 1'b1;
        @(negedge clk_i);
        mem_rd_gnt = 1'b0;
        repeat (7) @(negedge clk_i);
        n_checks++;
        if (trnsl_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: done %b expected 0 in 8th wait cycle", trnsl_done);
        end
        @(negedge clk_i);
        n_checks++;
        if ({trnsl_done, trnsl_allow, trnsl_err} !== 3'b101 || trnsl_sts !== 2'b00 || trnsl_ppa !== '0) begin
            n_fail++;
            $display("FAIL timeout: done/allow/err %b sts %b ppa %h expected 101 00 0",
                     {trnsl_done, trnsl_allow, trnsl_err}, trnsl_sts, trnsl_ppa);
        end
        mem_rd_rvalid = 1'b1;
        mem_rd_rdata  = ent(28'h777, 2'b01);
        @(negedge clk_i);
        mem_rd_rvalid = 1'b0;
        d0 = done_cnt;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (done_cnt != d0 || trnsl_ppa !== '0 || lkup_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL late_rvalid: extra dones %0d ppa %h ready %b expected 0 0 1",
                     done_cnt - d0, trnsl_ppa, lkup_ready);
        end
    endtask

    task automatic test_back_to_back_busy;
        int g0, d0;
        g0 = gnt_cnt;
        d0 = done_cnt;
        issue_lookup(28'h50, 1'b0);
        mem_rd_gnt = 1'b1;
        @(negedge clk_i);
        mem_rd_gnt = 1'b0;
        lkup_valid = 1'b1;
        lkup_hppa  = 28'h51;
        @(negedge clk_i);
        lkup_valid    = 1'b0;
        mem_rd_rvalid = 1'b1;
        mem_rd_rdata  = ent(28'hBEEF, 2'b01);
        @(negedge clk_i);
        mem_rd_rvalid = 1'b0;
        n_checks++;
        if (trnsl_done !== 1'b1 || trnsl_ppa !== 28'hBEEF) begin
            n_fail++;
            $display("FAIL busy_resp: done %b ppa %h expected 1 beef", trnsl_done, trnsl_ppa);
        end
        repeat (4) @(negedge clk_i);
        n_checks++;
        if (gnt_cnt - g0 != 1 || done_cnt - d0 != 1 || mem_rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_drop: grants %0d dones %0d req %b expected 1 1 0",
                     gnt_cnt - g0, done_cnt - d0, mem_rd_req);
        end
    endtask

    task automatic test_reset_mid;
        issue_lookup(28'h60, 1'b0);
        mem_rd_gnt = 1'b1;
        @(negedge clk_i);
        mem_rd_gnt = 1'b0;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({lkup_ready, mem_rd_req, trnsl_done} !== 3'b000 || trnsl_ppa !== '0 || mem_rd_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: ready/req/done %b ppa %h addr %h expected 000 0 0",
                     {lkup_ready, mem_rd_req, trnsl_done}, trnsl_ppa, mem_rd_addr);
        end
        @(negedge clk_i);
        rst_ni        = 1'b1;
        mem_rd_rvalid = 1'b1;
        mem_rd_rdata  = ent(28'h999, 2'b01);
        @(negedge clk_i);
        mem_rd_rvalid = 1'b0;
        n_checks++;
        if (trnsl_done !== 1'b0 || lkup_ready !== 1'b1 || trnsl_ppa !== '0) begin
            n_fail++;
            $display("FAIL reset_recover: done %b ready %b ppa %h expected 0 1 0", trnsl_done, lkup_ready, trnsl_ppa);
        end
    endtask

`ifdef HAWK_ATT_LKUP_CACHE_EN
    task automatic test_cache;
        issue_lookup(28'h70, 1'b0);
        mem_respond(0, 1, ent(28'h12345, 2'b11), 1'b0);
        @(negedge clk_i);
        issue_lookup(28'h70, 1'b0);
        n_checks++;
        if (trnsl_done !== 1'b1 || mem_rd_req !== 1'b0 || trnsl_allow !== 1'b1 ||
            trnsl_ppa !== 28'h12345 || trnsl_sts !== 2'b11) begin
            n_fail++;
            $display("FAIL cache_hit: done %b req %b allow %b ppa %h sts %b expected 1 0 1 12345 11",
                     trnsl_done, mem_rd_req, trnsl_allow, trnsl_ppa, trnsl_sts);
        end
        @(negedge clk_i);
        att_inval = 1'b1;
        @(negedge clk_i);
        att_inval = 1'b0;
        issue_lookup(28'h70, 1'b0);
        n_checks++;
        if (mem_rd_req !== 1'b1 || trnsl_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cache_inval: req %b done %b expected 1 0", mem_rd_req, trnsl_done);
        end
        mem_respond(0, 1, ent(28'h12345, 2'b11), 1'b0);
        @(negedge clk_i);
        issue_lookup(28'h70, 1'b1);
        n_checks++;
        if (mem_rd_req !== 1'b1 || trnsl_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cache_inval_coincident: req %b done %b expected 1 0", mem_rd_req, trnsl_done);
        end
        mem_respond(0, 1, ent(28'h12345, 2'b11), 1'b0);
        @(negedge clk_i);
    endtask
`else
    task automatic test_no_cache;
        issue_lookup(28'h70, 1'b0);
        mem_respond(0, 1, ent(28'h12345, 2'b11), 1'b0);
        @(negedge clk_i);
        issue_lookup(28'h70, 1'b0);
        n_checks++;
        if (mem_rd_req !== 1'b1 || trnsl_done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_cache_repeat: req %b done %b expected 1 0", mem_rd_req, trnsl_done);
        end
        mem_respond(0, 1, ent(28'h12345, 2'b11), 1'b0);
        n_checks++;
        if (trnsl_done !== 1'b1 || trnsl_ppa !== 28'h12345) begin
            n_fail++;
            $display("FAIL no_cache_resp: done %b ppa %h expected 1 12345", trnsl_done, trnsl_ppa);
        end
        @(negedge clk_i);
    endtask
`endif

    initial begin
        test_reset();
        test_uncompressed();
        test_compressed_unalloc();
        test_rd_error();
        test_gnt_data_same_cycle();
        test_timeout();
        test_back_to_back_busy();
        test_reset_mid();
`ifdef HAWK_ATT_LKUP_CACHE_EN
        test_cache();
`else
        test_no_cache();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
